// File: rtl/rx_desc_queue_if.sv
// Descriptor handshake between the MII receive engine, rx_desc_queue and the AXI register file.
// master = engine/register-file side, slave = the queue.
interface rx_desc_queue_if #(
  parameter int DEPTH_LOG2     = 3,
  parameter int RAM_ADDR_WIDTH = 11
);
  logic                      recv_pack_valid;
  logic [RAM_ADDR_WIDTH-1:0] recv_pack_addr;
  logic [RAM_ADDR_WIDTH-1:0] recv_pack_size;
  logic                      pop;
  logic                      ovf_clr;
  logic                      desc_valid;
  logic [31:0]               desc_data;
  logic [DEPTH_LOG2:0]       count;
  logic                      overflow;
  logic                      irq;
  logic [15:0]               drop_count;

  modport master (
    output recv_pack_valid, recv_pack_addr, recv_pack_size, pop, ovf_clr,
    input  desc_valid, desc_data, count, overflow, irq, drop_count
  );

  modport slave (
    input  recv_pack_valid, recv_pack_addr, recv_pack_size, pop, ovf_clr,
    output desc_valid, desc_data, count, overflow, irq, drop_count
  );
endinterface

// File: rtl/rx_desc_queue.sv
// Receive-descriptor FIFO: one {size, addr} entry per rising edge of recv_pack_valid, FWFT head.
// Optional saturating drop counter enabled by defining RXQ_DROP_COUNTER_EN.
module rx_desc_queue #(
  parameter int DEPTH_LOG2     = 3,
  parameter int RAM_ADDR_WIDTH = 11
) (
  input  logic            S_AXI_ACLK,
  input  logic            S_AXI_ARESETN,
  rx_desc_queue_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int ENT_W = 2 * RAM_ADDR_WIDTH;

  logic [ENT_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  prev;
  logic                  overflow_q;
  logic                  irq_q;

  logic push, full, empty, pop_ok, push_ok, drop;
  logic [ENT_W-1:0] head;

  assign push  = bus.recv_pack_valid & ~prev;
  assign full  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign pop_ok  = bus.pop & ~empty;
  // A pop in the same cycle frees the slot a full queue would otherwise lack.
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & ~push_ok;

  // Entry storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge S_AXI_ACLK) begin
    if (push_ok)
      mem[wr_ptr] <= {bus.recv_pack_size, bus.recv_pack_addr};
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      prev       <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      prev  <= bus.recv_pack_valid;
      irq_q <= push_ok;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop)             overflow_q <= 1'b1;
      else if (bus.ovf_clr) overflow_q <= 1'b0;
    end
  end

`ifdef RXQ_DROP_COUNTER_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      drop_cnt_q <= '0;
    end else if (drop) begin
      if (bus.ovf_clr)               drop_cnt_q <= 16'h0001;
      else if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'h0001;
    end else if (bus.ovf_clr) begin
      drop_cnt_q <= '0;
    end
  end

  assign bus.drop_count = drop_cnt_q;
`else
  assign bus.drop_count = 16'h0000;
`endif

  assign head = mem[rd_ptr];

  always_comb begin
    bus.desc_data = 32'h0;
    if (!empty)
      bus.desc_data = {16'(head[ENT_W-1:RAM_ADDR_WIDTH]), 16'(head[RAM_ADDR_WIDTH-1:0])};
  end

  assign bus.desc_valid = ~empty;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.irq        = irq_q;
endmodule

// File: tb/tb_rx_desc_queue.sv
// Directed bench for rx_desc_queue; expectations follow RXQ_DROP_COUNTER_EN when defined.
module tb_rx_desc_queue;
  logic S_AXI_ACLK = 1'b0;
  logic S_AXI_ARESETN;
  int   vec  = 0;
  int   miss = 0;

`ifdef RXQ_DROP_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  rx_desc_queue_if #(.DEPTH_LOG2(3), .RAM_ADDR_WIDTH(11)) bus ();

  rx_desc_queue #(.DEPTH_LOG2(3), .RAM_ADDR_WIDTH(11)) dut (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .S_AXI_ARESETN (S_AXI_ARESETN),
    .bus           (bus)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  task automatic cyc();
    @(posedge S_AXI_ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] desc(input int sz, input int ad);
    return {16'(sz), 16'(ad)};
  endfunction

  // Rising edge plus the mandatory low cycle.
  task automatic push_pkt(input int ad, input int sz);
    bus.recv_pack_valid = 1'b1;
    bus.recv_pack_addr  = 11'(ad);
    bus.recv_pack_size  = 11'(sz);
    cyc();
    bus.recv_pack_valid = 1'b0;
    cyc();
  endtask

  initial begin
    S_AXI_ARESETN       = 1'b0;
    bus.recv_pack_valid = 1'b1;
    bus.recv_pack_addr  = '0;
    bus.recv_pack_size  = '0;
    bus.pop             = 1'b0;
    bus.ovf_clr         = 1'b0;
    repeat (3) cyc();

    check("rst_desc_valid", 32'(bus.desc_valid), 32'd0);
    check("rst_desc_data",  bus.desc_data,       32'd0);
    check("rst_count",      32'(bus.count),      32'd0);
    check("rst_overflow",   32'(bus.overflow),   32'd0);
    check("rst_irq",        32'(bus.irq),        32'd0);
    check("rst_drop_count", 32'(bus.drop_count), 32'd0);

    // Level held high across reset release must not push
    S_AXI_ARESETN = 1'b1;
    cyc();
    check("held_high_count", 32'(bus.count), 32'd0);
    check("held_high_irq",   32'(bus.irq),   32'd0);
    cyc();
    check("held_high_count2", 32'(bus.count), 32'd0);
    bus.recv_pack_valid = 1'b0;
    cyc();

    // Single packet
    bus.recv_pack_valid = 1'b1;
    bus.recv_pack_addr  = 11'h040;
    bus.recv_pack_size  = 11'h05C;
    cyc();
    check("single_irq",   32'(bus.irq),        32'd1);
    check("single_valid", 32'(bus.desc_valid), 32'd1);
    check("single_data",  bus.desc_data,       32'h005C_0040);
    check("single_count", 32'(bus.count),      32'd1);
    bus.recv_pack_valid = 1'b0;
    cyc();
    check("single_irq_off", 32'(bus.irq), 32'd0);
    bus.pop = 1'b1;
    cyc();
    bus.pop = 1'b0;
    check("single_pop_valid", 32'(bus.desc_valid), 32'd0);
    check("single_pop_data",  bus.desc_data,       32'd0);
    check("single_pop_count", 32'(bus.count),      32'd0);

    // Fill and overflow: ninth edge is dropped
    for (int i = 0; i < 9; i++) begin
      bus.recv_pack_valid = 1'b1;
      bus.recv_pack_addr  = 11'(i);
      bus.recv_pack_size  = 11'(i + 16);
      cyc();
      check("fill_irq", 32'(bus.irq), (i < 8) ? 32'd1 : 32'd0);
      bus.recv_pack_valid = 1'b0;
      cyc();
    end
    check("fill_count",    32'(bus.count),      32'd8);
    check("fill_overflow", 32'(bus.overflow),   32'd1);
    check("fill_drop_cnt", 32'(bus.drop_count), CNT_EN ? 32'd1 : 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("fill_head", bus.desc_data, desc(i + 16, i));
      bus.pop = 1'b1;
      cyc();
      bus.pop = 1'b0;
    end
    check("drain_valid",    32'(bus.desc_valid), 32'd0);
    check("drain_overflow", 32'(bus.overflow),   32'd1);
    bus.pop = 1'b1;
    cyc();
    bus.pop = 1'b0;
    check("pop_empty_count", 32'(bus.count), 32'd0);
    bus.ovf_clr = 1'b1;
    cyc();
    bus.ovf_clr = 1'b0;
    check("clr_overflow", 32'(bus.overflow),   32'd0);
    check("clr_drop_cnt", 32'(bus.drop_count), 32'd0);

    // Wrap-around: 5 in, 5 out, 6 in
    for (int i = 0; i < 5; i++) begin
      push_pkt(12'h100 + i, 1);
      check("wrap_count_a", 32'(bus.count), 32'(i + 1));
    end
    for (int i = 0; i < 5; i++) begin
      check("wrap_head_a", bus.desc_data, desc(1, 12'h100 + i));
      bus.pop = 1'b1;
      cyc();
      bus.pop = 1'b0;
      check("wrap_count_b", 32'(bus.count), 32'(4 - i));
    end
    for (int i = 0; i < 6; i++) begin
      push_pkt(12'h200 + i, 2);
      check("wrap_count_c", 32'(bus.count), 32'(i + 1));
    end
    bus.pop = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("wrap_head_c", bus.desc_data, desc(2, 12'h200 + i));
      cyc();
    end
    bus.pop = 1'b0;
    check("wrap_empty", 32'(bus.count), 32'd0);

    // Simultaneous push and pop while full
    for (int i = 0; i < 8; i++) push_pkt(12'h300 + i, 3);
    bus.recv_pack_valid = 1'b1;
    bus.recv_pack_addr  = 11'h7AA;
    bus.recv_pack_size  = 11'h011;
    bus.pop             = 1'b1;
    cyc();
    bus.recv_pack_valid = 1'b0;
    bus.pop             = 1'b0;
    check("both_full_count", 32'(bus.count),    32'd8);
    check("both_full_ovf",   32'(bus.overflow), 32'd0);
    check("both_full_irq",   32'(bus.irq),      32'd1);
    check("both_full_head",  bus.desc_data,     desc(3, 12'h301));
    cyc();
    bus.pop = 1'b1;
    for (int i = 1; i < 8; i++) cyc();
    bus.pop = 1'b0;
    check("both_full_tail", bus.desc_data, 32'h0011_07AA);
    bus.pop = 1'b1;
    cyc();
    bus.pop = 1'b0;
    check("both_full_drained", 32'(bus.count), 32'd0);

    // Simultaneous push and pop while empty
    bus.recv_pack_valid = 1'b1;
    bus.recv_pack_addr  = 11'h123;
    bus.recv_pack_size  = 11'h045;
    bus.pop             = 1'b1;
    cyc();
    bus.recv_pack_valid = 1'b0;
    bus.pop             = 1'b0;
    check("both_empty_count", 32'(bus.count),      32'd1);
    check("both_empty_valid", 32'(bus.desc_valid), 32'd1);
    check("both_empty_head",  bus.desc_data,       32'h0045_0123);
    cyc();

    // Reset with 3 entries queued flushes everything
    push_pkt(12'h010, 4);
    push_pkt(12'h011, 4);
    check("pre_rst_count", 32'(bus.count), 32'd3);
    S_AXI_ARESETN = 1'b0;
    cyc();
    S_AXI_ARESETN = 1'b1;
    check("mid_rst_count", 32'(bus.count),      32'd0);
    check("mid_rst_valid", 32'(bus.desc_valid), 32'd0);
    cyc();
    check("post_rst_irq",   32'(bus.irq),   32'd0);
    check("post_rst_count", 32'(bus.count), 32'd0);

    // ovf_clr coinciding with a drop
    for (int i = 0; i < 8; i++) push_pkt(12'h400 + i, 5);
    bus.recv_pack_valid = 1'b1;
    bus.ovf_clr         = 1'b1;
    cyc();
    bus.recv_pack_valid = 1'b0;
    bus.ovf_clr         = 1'b0;
    check("clr_drop_ovf",   32'(bus.overflow),   32'd1);
    check("clr_drop_cnt",   32'(bus.drop_count), CNT_EN ? 32'd1 : 32'd0);
    check("clr_drop_count", 32'(bus.count),      32'd8);
    check("clr_drop_irq",   32'(bus.irq),        32'd0);
    cyc();
    bus.recv_pack_valid = 1'b1;
    cyc();
    bus.recv_pack_valid = 1'b0;
    check("second_drop_cnt", 32'(bus.drop_count), CNT_EN ? 32'd2 : 32'd0);
    check("second_drop_head", bus.desc_data, desc(5, 12'h400));

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
